// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
// ----------------------------------------------------------------------------
// Serial frame transmitter for the sequence-detection test path. A parallel
// word accepted over a valid/ready handshake is sent one bit per clock as:
//   sync pattern (MSB first) -> data word (MSB first) -> optional even parity
//   -> GAP idle cycles.
// The serial bit drives the single-bit input of the downstream detectors.
//
// Parameters
//   DATA_W        payload width (>=1)
//   SYNC_LEN      number of sync bits (>=1)
//   SYNC_PATTERN  sync bits, bit SYNC_LEN-1 sent first
//   PARITY        0 = no parity bit, 1 = append even parity after the data
//   GAP           idle cycles after each frame (>=0)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_data is offered
//   in_ready    word can be accepted this cycle (combinational)
//   in_data     payload word, captured on handshake
//   o           serial output bit
//   o_valid     o carries a sync, data or parity bit
//   busy        a frame or its gap is in progress
//   frame_done  one-cycle pulse in the cycle after the last frame bit
// ----------------------------------------------------------------------------
module seq_pattern_tx #(
  parameter int                  DATA_W       = 8,
  parameter int                  SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1011,
  parameter int                  PARITY       = 0,
  parameter int                  GAP          = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              o,
  output logic              o_valid,
  output logic              busy,
  output logic              frame_done
);

  // The single down-counter is reused by the sync, data and gap phases, so
  // it must be wide enough for the longest of the three.
  localparam int CNT_MAX_SD = (SYNC_LEN > DATA_W) ? SYNC_LEN - 1 : DATA_W - 1;
  localparam int CNT_MAX    = (GAP - 1 > CNT_MAX_SD) ? GAP - 1 : CNT_MAX_SD;
  localparam int CNT_W      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LAST_I);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PAR,
    S_GAP
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    bitCnt_q,    bitCnt_d;
  logic [DATA_W-1:0]   shreg_q,     shreg_d;
  logic                parAcc_q,    parAcc_d;
  logic                o_q,         o_d;
  logic                oValid_q,    oValid_d;
  logic                busy_q,      busy_d;
  logic                frameDone_q, frameDone_d;

  logic [SYNC_LEN-1:0] syncShifted;
  logic                handshake;

  // A word can only be taken while idle, and never on a reset edge, so the
  // ready flag is masked by rst directly rather than waiting a cycle.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign handshake = in_valid && in_ready;

  // Next-state logic. Each phase counts down from its last index to zero and
  // then hands over to the following phase with the counter preloaded. The
  // data shift register moves one place per data cycle and the parity
  // accumulator folds in the bit that was just on the wire, so by the time
  // the parity phase is entered it holds the XOR of the whole word.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shreg_d     = shreg_q;
    parAcc_d    = parAcc_q;
    frameDone_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          shreg_d  = in_data;
          bitCnt_d = SYNC_LAST;
          parAcc_d = 1'b0;
          state_d  = S_SYNC;
        end
      end

      S_SYNC: begin
        if (bitCnt_q == '0) begin
          bitCnt_d = DATA_LAST;
          state_d  = S_DATA;
        end else begin
          bitCnt_d = bitCnt_q - CNT_ONE;
        end
      end

      S_DATA: begin
        shreg_d  = shreg_q << 1;
        parAcc_d = parAcc_q ^ shreg_q[DATA_W-1];
        if (bitCnt_q == '0) begin
          if (PARITY != 0) begin
            state_d = S_PAR;
          end else begin
            frameDone_d = 1'b1;
            if (GAP > 0) begin
              bitCnt_d = GAP_LAST;
              state_d  = S_GAP;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          bitCnt_d = bitCnt_q - CNT_ONE;
        end
      end

      S_PAR: begin
        frameDone_d = 1'b1;
        if (GAP > 0) begin
          bitCnt_d = GAP_LAST;
          state_d  = S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GAP: begin
        if (bitCnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          bitCnt_d = bitCnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode. The serial outputs are registered, so they are decoded
  // from the *next* state: the bit presented in a cycle belongs to the state
  // the block is in during that cycle. This puts the first sync bit on the
  // wire in the cycle right after the handshake edge.
  always_comb begin
    syncShifted = SYNC_PATTERN >> bitCnt_d;
    o_d         = 1'b0;
    oValid_d    = 1'b0;
    busy_d      = (state_d != S_IDLE);

    case (state_d)
      S_SYNC: begin
        o_d      = syncShifted[0];
        oValid_d = 1'b1;
      end
      S_DATA: begin
        o_d      = shreg_d[DATA_W-1];
        oValid_d = 1'b1;
      end
      S_PAR: begin
        o_d      = parAcc_d;
        oValid_d = 1'b1;
      end
      default: begin
        o_d      = 1'b0;
        oValid_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset abandons any frame in flight without
  // a completion pulse and clears every piece of datapath state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bitCnt_q    <= '0;
      shreg_q     <= '0;
      parAcc_q    <= 1'b0;
      o_q         <= 1'b0;
      oValid_q    <= 1'b0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shreg_q     <= shreg_d;
      parAcc_q    <= parAcc_d;
      o_q         <= o_d;
      oValid_q    <= oValid_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign o          = o_q;
  assign o_valid    = oValid_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx
// ----------------------------------------------------------------------------
// Three transmitter instances share one clock and reset:
//   dut 0: defaults (DATA_W 8, sync 1011, no parity, GAP 2)
//   dut 1: PARITY 1, GAP 3
//   dut 2: DATA_W 1, SYNC_LEN 1, pattern 1, no parity, GAP 0
// A frame model builds the expected bit list from the word and the frame
// rules; each cycle the packed output vector
//   {o_valid, o, busy, frame_done, in_ready}
// is compared against what the model says that cycle should show.
// ----------------------------------------------------------------------------
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] inValid;
  logic [7:0] inData [3];
  logic [2:0] inReady;
  logic [2:0] oBit;
  logic [2:0] oValid;
  logic [2:0] busyO;
  logic [2:0] frameDone;

  int passCount  = 0;
  int checkCount = 0;

  bit frameQ [$];
  int matchCount;
  int matchPos;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  seq_pattern_tx dut0 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid[0]),
    .in_ready   (inReady[0]),
    .in_data    (inData[0]),
    .o          (oBit[0]),
    .o_valid    (oValid[0]),
    .busy       (busyO[0]),
    .frame_done (frameDone[0])
  );

  seq_pattern_tx #(
    .PARITY (1),
    .GAP    (3)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid[1]),
    .in_ready   (inReady[1]),
    .in_data    (inData[1]),
    .o          (oBit[1]),
    .o_valid    (oValid[1]),
    .busy       (busyO[1]),
    .frame_done (frameDone[1])
  );

  seq_pattern_tx #(
    .DATA_W       (1),
    .SYNC_LEN     (1),
    .SYNC_PATTERN (1'b1),
    .PARITY       (0),
    .GAP          (0)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid[2]),
    .in_ready   (inReady[2]),
    .in_data    (inData[2][0:0]),
    .o          (oBit[2]),
    .o_valid    (oValid[2]),
    .busy       (busyO[2]),
    .frame_done (frameDone[2])
  );

  // Per-instance configuration, mirroring the parameter overrides above.
  function automatic int syncLenOf(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  function automatic int syncPatOf(input int d);
    return (d == 2) ? 1 : 11;
  endfunction

  function automatic int dataWOf(input int d);
    return (d == 2) ? 1 : 8;
  endfunction

  function automatic int parityOf(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic int gapOf(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 0);
  endfunction

  function automatic logic [4:0] obsOf(input int d);
    return {oValid[d], oBit[d], busyO[d], frameDone[d], inReady[d]};
  endfunction

  // Frame model: the list of bits that must appear with o_valid high.
  task automatic buildFrame(input int d, input logic [7:0] word);
    int  pat;
    bit  p;
    pat = syncPatOf(d);
    frameQ.delete();
    for (int i = syncLenOf(d) - 1; i >= 0; i--) frameQ.push_back(pat[i]);
    for (int i = dataWOf(d) - 1; i >= 0; i--) frameQ.push_back(word[i]);
    if (parityOf(d) != 0) begin
      p = 1'b0;
      for (int i = 0; i < dataWOf(d); i++) p = p ^ word[i];
      frameQ.push_back(p);
    end
  endtask

  // Count a comparison and report it if it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Send one word to instance d starting from an idle negedge, then check
  // every cycle of the frame, its gap and the following idle cycle. With
  // holdValid the request stays up (carrying nextWord) so the next call
  // hands off back-to-back. Returns at the negedge of that idle cycle.
  task automatic applyStimulus(input int d, input logic [7:0] word,
                               input bit holdValid, input logic [7:0] nextWord);
    int         flen;
    int         glen;
    logic [4:0] expVec;
    logic [3:0] hist;
    buildFrame(d, word);
    flen = frameQ.size();
    glen = gapOf(d);
    checkOutput($sformatf("d%0d ready before %0h", d, word), 32'(inReady[d]), 32'd1);
    inValid[d] = 1'b1;
    inData[d]  = word;
    hist       = '0;
    matchCount = 0;
    matchPos   = -1;
    for (int j = 0; j <= flen + glen; j++) begin
      @(negedge clk);
      if (j < flen)
        expVec = {1'b1, frameQ[j], 1'b1, 1'b0, 1'b0};
      else if (j < flen + glen)
        expVec = {1'b0, 1'b0, 1'b1, (j == flen), 1'b0};
      else
        expVec = {1'b0, 1'b0, 1'b0, (glen == 0), 1'b1};
      checkOutput($sformatf("d%0d word %0h cycle %0d", d, word, j),
                  32'(obsOf(d)), 32'(expVec));
      hist = {hist[2:0], oBit[d]};
      if (hist == 4'b1011) begin
        matchCount++;
        matchPos = j;
      end
      if (j == 0) begin
        if (holdValid) begin
          inData[d] = nextWord;
        end else begin
          inValid[d] = 1'b0;
          inData[d]  = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] w;
    int         d;
    int         idleCycles;
    logic [4:0] expVec;

    rst     = 1'b1;
    inValid = '0;
    for (int i = 0; i < 3; i++) inData[i] = '0;

    // Reset state on every instance; in_ready follows rst falling at once.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("d%0d in reset", i), 32'(obsOf(i)), 32'd0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("d%0d after reset", i), 32'(obsOf(i)), 32'd1);

    $display("[TB] basic frames");
    applyStimulus(0, 8'hA5, 1'b0, 8'h00);
    applyStimulus(1, 8'h07, 1'b0, 8'h00);
    applyStimulus(1, 8'hA5, 1'b0, 8'h00);

    $display("[TB] back-to-back");
    applyStimulus(0, 8'h01, 1'b1, 8'hFF);
    applyStimulus(0, 8'hFF, 1'b0, 8'h00);
    applyStimulus(2, 8'h01, 1'b1, 8'h01);
    applyStimulus(2, 8'h01, 1'b0, 8'h00);

    $display("[TB] loopback into 1011 detector");
    applyStimulus(0, 8'h00, 1'b0, 8'h00);
    checkOutput("loopback match count", 32'(matchCount), 32'd1);
    checkOutput("loopback match position", 32'(matchPos), 32'd3);

    // Reset while the third data bit of an A5 frame is on the wire, with a
    // fresh request offered in the same cycle.
    $display("[TB] reset mid-frame");
    buildFrame(0, 8'hA5);
    inValid[0] = 1'b1;
    inData[0]  = 8'hA5;
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      expVec = {1'b1, frameQ[j], 1'b1, 1'b0, 1'b0};
      checkOutput($sformatf("d0 pre-reset cycle %0d", j), 32'(obsOf(0)), 32'(expVec));
      if (j == 0) inValid[0] = 1'b0;
    end
    rst        = 1'b1;
    inValid[0] = 1'b1;
    inData[0]  = 8'h3C;
    @(negedge clk);
    checkOutput("d0 after mid-frame reset", 32'(obsOf(0)), 32'd0);
    rst        = 1'b0;
    inValid[0] = 1'b0;
    #1;
    checkOutput("d0 ready after rst falls", 32'(obsOf(0)), 32'd1);
    @(negedge clk);
    checkOutput("d0 reset handshake ignored", 32'(obsOf(0)), 32'd1);

    $display("[TB] random frames");
    for (int n = 0; n < 24; n++) begin
      d          = int'($urandom_range(0, 1));
      w          = 8'($urandom);
      idleCycles = int'($urandom_range(0, 2));
      applyStimulus(d, w, 1'b0, 8'h00);
      for (int k = 0; k < idleCycles; k++) begin
        inData[d] = 8'($urandom);
        @(negedge clk);
        checkOutput($sformatf("d%0d idle %0d after %0h", d, k, w), 32'(obsOf(d)), 32'd1);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
